// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: I2S slave receiver in the SCK domain.
// Samples an externally mastered I2S stream, locks to the left-channel frame
// boundary and delivers each channel word as 16-bit halfwords with a
// one-cycle data_valid strobe. 32-bit words produce two strobes, upper
// halfword first.
// Optional feature macro: I2S_RX_FRAME_CHECK_EN. When it is defined, a short
// word sets the sticky frame_err flag and forces a relock. When it is
// undefined, frame_err is tied to 0.
module i2s_slave_rx (
    input  logic        rst_n,
    input  logic        sck_in,
    input  logic        enable,
    input  logic        word_size,
    input  logic        ws,
    input  logic        sd,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        data_ch,
    output logic        data_hi,
    output logic        locked,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_RECV = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ws_q;                // WS sampled on the previous edge
    logic        start_q, start_d;    // this edge is a word start (MSB)
    logic [5:0]  cnt_q, cnt_d;        // bits received in the current word, saturates at 32
    logic [15:0] shift_q, shift_d;
    logic        ch_q, ch_d;          // channel of the word being received
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        dch_q, dch_d;
    logic        dhi_q, dhi_d;
    logic        locked_q, locked_d;

    logic        ws_change;
    logic        ws_fall;
    logic [5:0]  cnt_inc;
    logic        hit16;
    logic        hit32;

`ifdef I2S_RX_FRAME_CHECK_EN
    logic        err_q, err_d;
    logic [5:0]  word_len;
    assign word_len = word_size ? 6'd32 : 6'd16;
`endif

    assign ws_change = ws ^ ws_q;
    assign ws_fall   = ws_q & ~ws;

    // A word start restarts the count at 1, because the MSB is taken on that edge.
    assign cnt_inc = start_q ? 6'd1 : ((cnt_q == 6'd32) ? cnt_q : cnt_q + 6'd1);
    assign hit16   = (cnt_inc == 6'd16);
    assign hit32   = word_size && (cnt_q == 6'd31) && !start_q;

    // Next-state and output logic for the lock/receive FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        start_d  = 1'b0;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ch_d     = ch_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        dch_d    = dch_q;
        dhi_d    = dhi_q;
        locked_d = locked_q;
`ifdef I2S_RX_FRAME_CHECK_EN
        err_d    = err_q;
`endif
        if (!enable) begin
            // Leaving for IDLE drops any partial halfword and the lock.
            state_d  = S_IDLE;
            locked_d = 1'b0;
            cnt_d    = '0;
`ifdef I2S_RX_FRAME_CHECK_EN
            err_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    locked_d = 1'b0;
                    cnt_d    = '0;
`ifdef I2S_RX_FRAME_CHECK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = S_SYNC;
                end
                S_SYNC: begin
                    locked_d = 1'b0;
                    start_d  = ws_fall;
                    if (start_q) begin
                        // This edge carries the left-channel MSB.
                        state_d  = S_RECV;
                        locked_d = 1'b1;
                        start_d  = ws_change;
                        cnt_d    = 6'd1;
                        shift_d  = {shift_q[14:0], sd};
                        ch_d     = ws_q;
                    end
                end
                S_RECV: begin
                    // This edge's bit belongs to the old word even if WS changes here.
                    start_d = ws_change;
                    shift_d = {shift_q[14:0], sd};
                    cnt_d   = cnt_inc;
                    if (start_q) begin
                        ch_d = ws_q;
                    end
                    if (hit16 || hit32) begin
                        data_d  = {shift_q[14:0], sd};
                        valid_d = 1'b1;
                        dch_d   = ch_q;
                        dhi_d   = hit16;
                    end
`ifdef I2S_RX_FRAME_CHECK_EN
                    if (ws_change && (cnt_inc < word_len)) begin
                        err_d    = 1'b1;
                        state_d  = S_SYNC;
                        locked_d = 1'b0;
                        start_d  = 1'b0;
                    end
`endif
                end
                default: begin
                    state_d  = S_IDLE;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers. rst_n is asynchronous and active-low.
    always_ff @(posedge sck_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ws_q     <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            ch_q     <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            dch_q    <= 1'b0;
            dhi_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the same pre-edge values.
            state_q  <= state_d;
            ws_q     <= ws;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ch_q     <= ch_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            dch_q    <= dch_d;
            dhi_q    <= dhi_d;
            locked_q <= locked_d;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    // Sticky short-word flag. It is cleared by reset or by passing through IDLE.
    always_ff @(posedge sck_in or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign data_ch    = dch_q;
    assign data_hi    = dhi_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: directed testbench for i2s_slave_rx.
// The bench builds I2S streams from slot descriptions. Expected strobes, the
// lock window and the frame_err window come from the known slot positions in
// each stream. One compare process checks every edge against those expectations.
module tb_i2s_slave_rx;

    localparam int BIG = 1000000000;

    logic        rst_n, sck_in, enable, word_size, ws, sd;
    logic [15:0] data_out;
    logic        data_valid, data_ch, data_hi, locked, frame_err;

    i2s_slave_rx dut (
        .rst_n      (rst_n),
        .sck_in     (sck_in),
        .enable     (enable),
        .word_size  (word_size),
        .ws         (ws),
        .sd         (sd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ch    (data_ch),
        .data_hi    (data_hi),
        .locked     (locked),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic [15:0] d;
        logic        ch;
        logic        hi;
    } strobe_t;

    strobe_t exp_map [int];   // expected strobe, keyed by rising-edge number
    int      lock_lo[$];
    int      lock_hi[$];
    int      err_lo = -1;
    int      err_hi = -1;
    int      edge_n = 0;
    int      e0 = 0;          // edge that samples bit 0 of the current stream
    int      n_checks = 0;
    int      n_fail = 0;
    bit      sdq[$];
    bit      chq[$];

    initial sck_in = 1'b0;
    always #5 sck_in = ~sck_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic exp_locked(input int n);
        foreach (lock_lo[i]) begin
            if (n >= lock_lo[i] && n <= lock_hi[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_err(input int n);
        return (err_lo >= 0) && (n >= err_lo) && (n <= err_hi);
    endfunction

    // Per-edge compare, sampled 1 time unit after the rising edge.
    always @(posedge sck_in) begin
        edge_n++;
        #1;
        if (exp_map.exists(edge_n)) begin
            check("data_valid", {31'd0, data_valid}, 32'd1);
            check("data_out", {16'd0, data_out}, {16'd0, exp_map[edge_n].d});
            check("data_ch", {31'd0, data_ch}, {31'd0, exp_map[edge_n].ch});
            check("data_hi", {31'd0, data_hi}, {31'd0, exp_map[edge_n].hi});
            exp_map.delete(edge_n);
        end else begin
            check("data_valid idle", {31'd0, data_valid}, 32'd0);
        end
        check("locked", {31'd0, locked}, {31'd0, exp_locked(edge_n)});
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_err(edge_n)});
    end

    task automatic new_stream();
        sdq.delete();
        chq.delete();
    endtask

    // One slot of slen SCKs on channel ch. The first wbits bits carry val MSB-first,
    // and any bits after that are junk.
    task automatic add_slot(input logic ch, input logic [31:0] val, input int wbits,
                            input int slen, input logic [31:0] junk);
        for (int k = 0; k < slen; k++) begin
            chq.push_back(ch);
            if (k < wbits) sdq.push_back(val[wbits-1-k]);
            else           sdq.push_back(junk[k % 32]);
        end
    endtask

    task automatic begin_stream();
        @(negedge sck_in);
        e0 = edge_n + 1;
        lock_lo.delete();
        lock_hi.delete();
        err_lo = -1;
        err_hi = -1;
    endtask

    task automatic add_lock(input int rel);
        lock_lo.push_back(e0 + rel);
        lock_hi.push_back(BIG);
    endtask

    task automatic exp_strobe(input int rel, input logic [15:0] d, input logic ch, input logic hi);
        exp_map[e0 + rel] = '{d: d, ch: ch, hi: hi};
    endtask

    // Drive the stream. WS leads the data by one bit, which is the standard I2S delay.
    task automatic play(input int en_at, input int rst_at, input int rst_len);
        int n;
        n = sdq.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge sck_in);
            ws = (i + 1 < n) ? chq[i+1] : chq[n-1];
            sd = sdq[i];
            if (i == en_at) enable = 1'b1;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst data_out", {16'd0, data_out}, 32'd0);
                check("rst data_valid", {31'd0, data_valid}, 32'd0);
                check("rst data_ch", {31'd0, data_ch}, 32'd0);
                check("rst data_hi", {31'd0, data_hi}, 32'd0);
                check("rst locked", {31'd0, locked}, 32'd0);
                check("rst frame_err", {31'd0, frame_err}, 32'd0);
            end
            if (rst_at >= 0 && i == rst_at + rst_len) rst_n = 1'b1;
        end
    endtask

    task automatic setup(input logic mode);
        word_size = mode;
        enable    = 1'b1;
        repeat (2) @(negedge sck_in);
    endtask

    task automatic do_disable();
        @(negedge sck_in);
        enable = 1'b0;
        foreach (lock_hi[i]) begin
            if (lock_hi[i] == BIG) lock_hi[i] = edge_n;
        end
        if (err_lo >= 0 && err_hi == BIG) err_hi = edge_n;
        repeat (3) @(negedge sck_in);
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; word_size = 1'b0; ws = 1'b0; sd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset data_out", {16'd0, data_out}, 32'd0);
        check("reset data_valid", {31'd0, data_valid}, 32'd0);
        check("reset locked", {31'd0, locked}, 32'd0);
        check("reset data_hi", {31'd0, data_hi}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        repeat (3) @(negedge sck_in);
        rst_n = 1'b1;
        repeat (2) @(negedge sck_in);

        // A: 16-bit words in 16-bit slots
        setup(1'b0);
        new_stream();
        add_slot(1'b1, 32'h0, 0, 16, 32'h6C3A95E1);
        add_slot(1'b0, 32'hA55A, 16, 16, 32'h0);
        add_slot(1'b1, 32'h1234, 16, 16, 32'h0);
        add_slot(1'b0, 32'hC3C3, 16, 16, 32'h0);
        begin_stream();
        add_lock(16);
        exp_strobe(31, 16'hA55A, 1'b0, 1'b1);
        exp_strobe(47, 16'h1234, 1'b1, 1'b1);
        exp_strobe(63, 16'hC3C3, 1'b0, 1'b1);
        play(-1, -1, 0);
        do_disable();
        check("A held data_out", {16'd0, data_out}, 32'h0000C3C3);
        check("A held data_hi", {31'd0, data_hi}, 32'd1);

        // B: 32-bit words
        setup(1'b1);
        new_stream();
        add_slot(1'b1, 32'h0, 0, 32, 32'h9E3779B9);
        add_slot(1'b0, 32'hDEADBEEF, 32, 32, 32'h0);
        add_slot(1'b1, 32'h0BADF00D, 32, 32, 32'h0);
        add_slot(1'b0, 32'h13579BDF, 32, 32, 32'h0);
        begin_stream();
        add_lock(32);
        exp_strobe(47,  16'hDEAD, 1'b0, 1'b1);
        exp_strobe(63,  16'hBEEF, 1'b0, 1'b0);
        exp_strobe(79,  16'h0BAD, 1'b1, 1'b1);
        exp_strobe(95,  16'hF00D, 1'b1, 1'b0);
        exp_strobe(111, 16'h1357, 1'b0, 1'b1);
        exp_strobe(127, 16'h9BDF, 1'b0, 1'b0);
        play(-1, -1, 0);
        do_disable();
        check("B held data_out", {16'd0, data_out}, 32'h00009BDF);
        check("B held data_hi", {31'd0, data_hi}, 32'd0);

        // C: 16-bit words in 32-bit slots; the trailing junk bits are ignored
        setup(1'b0);
        new_stream();
        add_slot(1'b1, 32'h0, 0, 32, 32'h55AA33CC);
        add_slot(1'b0, 32'h8001, 16, 32, 32'hB7E1FFFF);
        add_slot(1'b1, 32'h4002, 16, 32, 32'hFFFF0F0F);
        begin_stream();
        add_lock(32);
        exp_strobe(47, 16'h8001, 1'b0, 1'b1);
        exp_strobe(79, 16'h4002, 1'b1, 1'b1);
        play(-1, -1, 0);
        do_disable();
        check("C held data_ch", {31'd0, data_ch}, 32'd1);

        // D: enable is raised during a right-channel word
        word_size = 1'b0;
        new_stream();
        add_slot(1'b0, 32'h1111, 16, 16, 32'h0);
        add_slot(1'b1, 32'h2222, 16, 16, 32'h0);
        add_slot(1'b0, 32'h3333, 16, 16, 32'h0);
        add_slot(1'b1, 32'h4444, 16, 16, 32'h0);
        begin_stream();
        add_lock(32);
        exp_strobe(47, 16'h3333, 1'b0, 1'b1);
        exp_strobe(63, 16'h4444, 1'b1, 1'b1);
        play(20, -1, 0);
        do_disable();

        // E: 32-bit mode with a left word that is cut short after 20 bits
        setup(1'b1);
        new_stream();
        add_slot(1'b1, 32'h0, 0, 32, 32'hA5A5C3C3);
        add_slot(1'b0, 32'hCAFEF00D, 32, 20, 32'h0);
        add_slot(1'b1, 32'h11223344, 32, 32, 32'h0);
        add_slot(1'b0, 32'h55667788, 32, 32, 32'h0);
        add_slot(1'b1, 32'h99AABBCC, 32, 32, 32'h0);
        begin_stream();
        exp_strobe(47, 16'hCAFE, 1'b0, 1'b1);
`ifdef I2S_RX_FRAME_CHECK_EN
        lock_lo.push_back(e0 + 32);
        lock_hi.push_back(e0 + 50);
        err_lo = e0 + 51;
        err_hi = BIG;
        add_lock(84);
`else
        add_lock(32);
        exp_strobe(67, 16'h1122, 1'b1, 1'b1);
        exp_strobe(83, 16'h3344, 1'b1, 1'b0);
`endif
        exp_strobe(99,  16'h5566, 1'b0, 1'b1);
        exp_strobe(115, 16'h7788, 1'b0, 1'b0);
        exp_strobe(131, 16'h99AA, 1'b1, 1'b1);
        exp_strobe(147, 16'hBBCC, 1'b1, 1'b0);
        play(-1, -1, 0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("E frame_err sticky", {31'd0, frame_err}, 32'd1);
`else
        check("E frame_err tied", {31'd0, frame_err}, 32'd0);
`endif
        do_disable();
        check("E frame_err after idle", {31'd0, frame_err}, 32'd0);

        // F: reset at bit 10 of a right word, then relock on the next left frame
        setup(1'b0);
        new_stream();
        add_slot(1'b1, 32'h0, 0, 16, 32'h12345678);
        add_slot(1'b0, 32'h0F0F, 16, 16, 32'h0);
        add_slot(1'b1, 32'hF0F0, 16, 16, 32'h0);
        add_slot(1'b0, 32'h6996, 16, 16, 32'h0);
        add_slot(1'b1, 32'h7777, 16, 16, 32'h0);
        add_slot(1'b0, 32'h1357, 16, 16, 32'h0);
        add_slot(1'b1, 32'h2468, 16, 16, 32'h0);
        begin_stream();
        lock_lo.push_back(e0 + 16);
        lock_hi.push_back(e0 + 41);
        add_lock(48);
        exp_strobe(31,  16'h0F0F, 1'b0, 1'b1);
        exp_strobe(63,  16'h6996, 1'b0, 1'b1);
        exp_strobe(79,  16'h7777, 1'b1, 1'b1);
        exp_strobe(95,  16'h1357, 1'b0, 1'b1);
        exp_strobe(111, 16'h2468, 1'b1, 1'b1);
        play(-1, 42, 4);
        do_disable();

        check("no strobes left pending", exp_map.num(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
